// File: rtl/hazard_detection_if.sv
// Hazard controller bundle: ID/EX hazard inputs in, pipeline enables and flushes out.
// Purely combinational grouping; carries no state or latency of its own.
// master = pipeline datapath side, slave = hazard_detection controller side.
interface hazard_detection_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       IF_ID_Rs;
  logic [4:0]       IF_ID_Rt;
  logic             IF_ID_uses_Rt;
  logic             ID_EX_MemRead;
  logic [4:0]       ID_EX_Rd;
  logic             EX_branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             PC_write;
  logic             IF_ID_write;
  logic             ID_EX_bubble;
  logic             IF_ID_flush;
  logic             ID_EX_flush;
  logic             pipe_freeze;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output IF_ID_Rs, IF_ID_Rt, IF_ID_uses_Rt, ID_EX_MemRead, ID_EX_Rd,
           EX_branch_taken, mem_req, mem_ready,
    input  PC_write, IF_ID_write, ID_EX_bubble, IF_ID_flush, ID_EX_flush,
           pipe_freeze, stall_count
  );

  modport slave (
    input  IF_ID_Rs, IF_ID_Rt, IF_ID_uses_Rt, ID_EX_MemRead, ID_EX_Rd,
           EX_branch_taken, mem_req, mem_ready,
    output PC_write, IF_ID_write, ID_EX_bubble, IF_ID_flush, ID_EX_flush,
           pipe_freeze, stall_count
  );
endinterface

// File: rtl/hazard_detection.sv
// ID-stage hazard/stall controller: load-use bubbles, memory freeze, branch flush.
// Latency: outputs are combinational from state and inputs (same cycle).
// Backpressure: mem_req && !mem_ready freezes the pipe until mem_ready; HAZARD_STATS_EN adds stall_count.
module hazard_detection #(
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input logic               clk,
  input logic               reset,
  hazard_detection_if.slave hd
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] LU_STALL = 2'd1;
  localparam logic [1:0] MEM_WAIT = 2'd2;
  localparam logic [3:0] LAT_M1   = 4'(LOAD_LAT - 1);

  logic [1:0] state, state_nx;
  logic [1:0] ret_state, ret_nx;
  logic [3:0] cnt, cnt_nx;
  logic       lu_hazard, mem_stall;
  logic       pc_write_c, if_id_write_c, bubble_c, if_flush_c, ex_flush_c, freeze_c;

  assign lu_hazard = hd.ID_EX_MemRead && (hd.ID_EX_Rd != 5'd0) &&
                     ((hd.ID_EX_Rd == hd.IF_ID_Rs) ||
                      (hd.IF_ID_uses_Rt && (hd.ID_EX_Rd == hd.IF_ID_Rt)));
  assign mem_stall = hd.mem_req && !hd.mem_ready;

  // Next-state and output decode; memory freeze wins over branch flush wins over load-use bubble.
  always_comb begin
    pc_write_c    = 1'b1;
    if_id_write_c = 1'b1;
    bubble_c      = 1'b0;
    if_flush_c    = 1'b0;
    ex_flush_c    = 1'b0;
    freeze_c      = 1'b0;
    state_nx      = state;
    ret_nx        = ret_state;
    cnt_nx        = cnt;
    case (state)
      RUN: begin
        if (mem_stall) begin
          pc_write_c    = 1'b0;
          if_id_write_c = 1'b0;
          freeze_c      = 1'b1;
          state_nx      = MEM_WAIT;
          ret_nx        = RUN;
        end else if (hd.EX_branch_taken) begin
          // The instruction in ID is squashed, so its load-use hazard is moot.
          if_flush_c = 1'b1;
          ex_flush_c = 1'b1;
        end else if (lu_hazard) begin
          pc_write_c    = 1'b0;
          if_id_write_c = 1'b0;
          bubble_c      = 1'b1;
          if (LOAD_LAT > 1) begin
            cnt_nx   = LAT_M1;
            state_nx = LU_STALL;
          end
        end
      end
      LU_STALL: begin
        pc_write_c    = 1'b0;
        if_id_write_c = 1'b0;
        if (mem_stall) begin
          // Remaining bubble count is preserved across the freeze.
          freeze_c = 1'b1;
          state_nx = MEM_WAIT;
          ret_nx   = LU_STALL;
        end else if (hd.EX_branch_taken) begin
          pc_write_c    = 1'b1;
          if_id_write_c = 1'b1;
          if_flush_c    = 1'b1;
          ex_flush_c    = 1'b1;
          cnt_nx        = 4'd0;
          state_nx      = RUN;
        end else begin
          bubble_c = 1'b1;
          cnt_nx   = cnt - 4'd1;
          if (cnt <= 4'd1) state_nx = RUN;
        end
      end
      MEM_WAIT: begin
        // EX is frozen, so a taken branch here is seen again after release.
        pc_write_c    = 1'b0;
        if_id_write_c = 1'b0;
        freeze_c      = 1'b1;
        if (hd.mem_ready) state_nx = ret_state;
      end
      default: state_nx = RUN;
    endcase
  end

  // Controller state; reset aborts any stall in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      ret_state <= RUN;
      cnt       <= 4'd0;
    end else begin
      state     <= state_nx;
      ret_state <= ret_nx;
      cnt       <= cnt_nx;
    end
  end

  // Reset forces the free-running enables regardless of hazard inputs.
  assign hd.PC_write     = reset | pc_write_c;
  assign hd.IF_ID_write  = reset | if_id_write_c;
  assign hd.ID_EX_bubble = ~reset & bubble_c;
  assign hd.IF_ID_flush  = ~reset & if_flush_c;
  assign hd.ID_EX_flush  = ~reset & ex_flush_c;
  assign hd.pipe_freeze  = ~reset & freeze_c;

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q;

  // Saturating count of cycles in which the PC is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (!pc_write_c && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign hd.stall_count = stall_cnt_q;
`else
  assign hd.stall_count = '0;
`endif

endmodule

// File: tb/tb_hazard_detection.sv
// Self-checking bench for hazard_detection: LOAD_LAT=1 (2-bit stats) and LOAD_LAT=3 instances.
// Vectors drive one instance per cycle; expected outputs queue up and are checked mid-cycle.
// Stats checks follow HAZARD_STATS_EN (counts when defined, zero otherwise).
module tb_hazard_detection;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_detection_if #(.CNT_W(2))  if1 ();
  hazard_detection_if #(.CNT_W(16)) if3 ();

  hazard_detection #(.LOAD_LAT(1), .CNT_W(2))  d1 (.clk(clk), .reset(rst), .hd(if1));
  hazard_detection #(.LOAD_LAT(3), .CNT_W(16)) d3 (.clk(clk), .reset(rst), .hd(if3));

  // Expected output code: {PC_write, IF_ID_write, ID_EX_bubble, IF_ID_flush, ID_EX_flush, pipe_freeze}
  localparam logic [5:0] EN = 6'b110000;
  localparam logic [5:0] BU = 6'b001000;
  localparam logic [5:0] FR = 6'b000001;
  localparam logic [5:0] FL = 6'b110110;

  typedef struct {
    int         tag;
    bit         sel;      // 0: LOAD_LAT=1 instance, 1: LOAD_LAT=3 instance
    bit         rst;
    logic [4:0] rs;
    logic [4:0] rt;
    bit         uses_rt;
    bit         memread;
    logic [4:0] rd;
    bit         br;
    bit         mreq;
    bit         mrdy;
    logic [5:0] exp;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(int tag, bit sel, bit r, logic [4:0] rs, logic [4:0] rt, bit ut,
                              bit mr, logic [4:0] rd, bit br, bit mq, bit my, logic [5:0] exp);
    vec_t v;
    v.tag = tag; v.sel = sel; v.rst = r; v.rs = rs; v.rt = rt; v.uses_rt = ut;
    v.memread = mr; v.rd = rd; v.br = br; v.mreq = mq; v.mrdy = my; v.exp = exp;
    return v;
  endfunction

  function automatic vec_t idle(int tag, bit sel, logic [5:0] exp);
    return mk(tag, sel, 1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, exp);
  endfunction

  task automatic drive(input vec_t v);
    rst = v.rst;
    if1.IF_ID_Rs = v.sel ? 5'd1 : v.rs;
    if1.IF_ID_Rt = v.sel ? 5'd2 : v.rt;
    if1.IF_ID_uses_Rt = v.sel ? 1'b0 : v.uses_rt;
    if1.ID_EX_MemRead = v.sel ? 1'b0 : v.memread;
    if1.ID_EX_Rd = v.sel ? 5'd0 : v.rd;
    if1.EX_branch_taken = v.sel ? 1'b0 : v.br;
    if1.mem_req = v.sel ? 1'b0 : v.mreq;
    if1.mem_ready = v.sel ? 1'b0 : v.mrdy;
    if3.IF_ID_Rs = v.sel ? v.rs : 5'd1;
    if3.IF_ID_Rt = v.sel ? v.rt : 5'd2;
    if3.IF_ID_uses_Rt = v.sel ? v.uses_rt : 1'b0;
    if3.ID_EX_MemRead = v.sel ? v.memread : 1'b0;
    if3.ID_EX_Rd = v.sel ? v.rd : 5'd0;
    if3.EX_branch_taken = v.sel ? v.br : 1'b0;
    if3.mem_req = v.sel ? v.mreq : 1'b0;
    if3.mem_ready = v.sel ? v.mrdy : 1'b0;
  endtask

  task automatic check_out();
    vec_t       e;
    logic [5:0] act;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty");
      return;
    end
    e = sb.pop_front();
    act = e.sel ? {if3.PC_write, if3.IF_ID_write, if3.ID_EX_bubble,
                   if3.IF_ID_flush, if3.ID_EX_flush, if3.pipe_freeze}
                : {if1.PC_write, if1.IF_ID_write, if1.ID_EX_bubble,
                   if1.IF_ID_flush, if1.ID_EX_flush, if1.pipe_freeze};
    checks++;
    if (act !== e.exp) begin
      errors++;
      $display("FAIL vec%0d dut%0d outputs got %b want %b (pcw,ifw,bub,iff,exf,frz)",
               e.tag, e.sel ? 3 : 1, act, e.exp);
    end
  endtask

  task automatic apply(input vec_t v);
    drive(v);
    sb.push_back(v);
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input int tag, input bit sel, input int exp_on);
    int act;
    int exp;
`ifdef HAZARD_STATS_EN
    exp = exp_on;
`else
    exp = 0;
`endif
    @(negedge clk);
    act = sel ? int'(if3.stall_count) : int'(if1.stall_count);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL cnt%0d dut%0d stall_count got %0d want %0d", tag, sel ? 3 : 1, act, exp);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with live hazard / mem-stall inputs: enables still forced on.
    apply(mk(0, 1'b0, 1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, EN));
    apply(mk(1, 1'b1, 1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, EN));
    check_cnt(1, 1'b0, 0);

    // Single-cycle patterns on the LOAD_LAT=1 instance.
    tbl.push_back(idle(10, 1'b0, EN));
    tbl.push_back(mk(11, 1'b0, 1'b0, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, BU));
    tbl.push_back(idle(12, 1'b0, EN));
    tbl.push_back(mk(13, 1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, EN));
    tbl.push_back(mk(14, 1'b0, 1'b0, 5'd3, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, EN));
    tbl.push_back(mk(15, 1'b0, 1'b0, 5'd3, 5'd5, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, EN));
    tbl.push_back(mk(16, 1'b0, 1'b0, 5'd3, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, BU));
    tbl.push_back(idle(17, 1'b0, EN));
    tbl.push_back(mk(18, 1'b0, 1'b0, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, FL));
    tbl.push_back(idle(19, 1'b0, EN));
    tbl.push_back(mk(20, 1'b0, 1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, EN));
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      if (tbl[i].tag == 12) check_cnt(12, 1'b0, 1);
    end

    // Memory not ready for 4 cycles, ready on the 5th: 5 frozen cycles, then run.
    for (int i = 0; i < 4; i++)
      apply(mk(30 + i, 1'b0, 1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, FR));
    apply(mk(34, 1'b0, 1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, FR));
    apply(idle(35, 1'b0, EN));

    // Branch during memory wait is held off until the freeze releases.
    apply(mk(40, 1'b0, 1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, FR));
    apply(mk(41, 1'b0, 1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, FR));
    apply(mk(42, 1'b0, 1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, FR));
    apply(mk(43, 1'b0, 1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, FL));
    apply(idle(44, 1'b0, EN));
    check_cnt(44, 1'b0, 3);  // 2-bit counter saturates

    // LOAD_LAT=3, hazard on rs2: three bubbles, RUN on the 4th cycle.
    apply(mk(50, 1'b1, 1'b0, 5'd4, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, BU));
    apply(idle(51, 1'b1, BU));
    apply(idle(52, 1'b1, BU));
    apply(idle(53, 1'b1, EN));
    check_cnt(53, 1'b1, 3);

    // Memory stall on the last LU_STALL cycle: freeze, then one bubble left.
    apply(mk(60, 1'b1, 1'b0, 5'd7, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, BU));
    apply(idle(61, 1'b1, BU));
    apply(mk(62, 1'b1, 1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, FR));
    apply(mk(63, 1'b1, 1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, FR));
    apply(mk(64, 1'b1, 1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, FR));
    apply(idle(65, 1'b1, BU));
    apply(idle(66, 1'b1, EN));
    check_cnt(66, 1'b1, 9);

    // Taken branch while in LU_STALL: flush and return to RUN.
    apply(mk(70, 1'b1, 1'b0, 5'd9, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, BU));
    apply(mk(71, 1'b1, 1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, FL));
    apply(idle(72, 1'b1, EN));

    // Branch and load-use hazard together: flush wins, no bubble.
    apply(mk(80, 1'b1, 1'b0, 5'd9, 5'd0, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, FL));
    apply(idle(81, 1'b1, EN));
    check_cnt(81, 1'b1, 10);

    // Reset pulse mid-stall clears state and statistics.
    apply(mk(90, 1'b1, 1'b0, 5'd6, 5'd0, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, BU));
    apply(mk(91, 1'b1, 1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, EN));
    apply(idle(92, 1'b1, EN));
    check_cnt(92, 1'b1, 0);
    // Fresh hazard after reset takes the full three bubbles again.
    apply(mk(93, 1'b1, 1'b0, 5'd6, 5'd0, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, BU));
    apply(idle(94, 1'b1, BU));
    apply(idle(95, 1'b1, BU));
    apply(idle(96, 1'b1, EN));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
